placar_multi: RTL and testbench
===============================

Name: placar_multi

Overview:
Parametrised match scoreboard for the Bulls and Cows game, and the successor to the two-player, fixed-width scoring block. It takes per-player round-win signals from the game core and keeps a saturating score for each of N players. It detects when the match is over, reports the winner and drives a per-player LED thermometer, with a blinking winner segment. It sits between the game core and the board LEDs; new_match restarts a match without a full reset.

Parameters:
N_PLAYERS, 2, number of players (>=2)
SCORE_W, 4, bits per score counter
WIN_TARGET, 8, score that ends the match (1 <= WIN_TARGET < 2**SCORE_W)
LED_W, 16, LED output width (>= N_PLAYERS)
BLINK_DIV, 50_000_000, clock cycles per blink half-period (>=1)
EDGE_DETECT, 1, 1 = count rising edges of win[i]; 0 = win[i] is already a 1-cycle pulse

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
win  in  N_PLAYERS  round-win indication per player, from game core
new_match  in  1  synchronous 1-cycle pulse to restart the match
scores  out  N_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W]
led  out  LED_W  LED display image
match_over  out  1  high while in OVER state
winner  out  max(1,$clog2(N_PLAYERS))  index of match winner, valid while match_over
rounds  out  8  rounds played in current match, saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): scores, led, match_over, winner, rounds, blink counter, blink phase and win_q all 0; state PLAYING.
- Edge detection: win_q <= win every cycle, in all states.
  - EDGE_DETECT=1: ev[i] = win[i] & ~win_q[i]. A level held N cycles counts once.
  - EDGE_DETECT=0: ev = win.
- FSM states: PLAYING, OVER.
- PLAYING, ev has exactly one bit i set:
  - score[i] += 1; rounds += 1 (saturating).
  - The update is visible on scores on the edge that samples the event (latency 1 clock).
  - If the new score[i] == WIN_TARGET: same edge, state <= OVER, match_over <= 1, winner <= i, blink phase <= 1, blink counter <= 0.
- PLAYING, ev has more than one bit set (simultaneous wins): drawn round. No score changes; rounds += 1.
- PLAYING, ev == 0: no change.
- OVER: ev is ignored. Scores and rounds are frozen. The blink counter counts 0..BLINK_DIV-1 and phase toggles on each wrap.
- new_match (either state):
  - Next edge: scores=0, rounds=0, match_over=0, winner=0, blink cleared, state PLAYING.
  - It has priority over any ev in the same cycle; that event is discarded.
  - win_q still updates, so a held win does not re-count afterwards.
- LED mapping, registered (one cycle after scores):
  - SEG = LED_W / N_PLAYERS. Player i owns led[i*SEG +: SEG].
  - Each segment is a thermometer: its low min(score_i, SEG) bits are 1.
  - Bits above N_PLAYERS*SEG are always 0.
  - In OVER, the winner's segment is all-ones when phase=1 and all-zeros when phase=0. Other segments keep their steady thermometers.
- Width rules:
  - Score increments cannot exceed WIN_TARGET, because the match ends there, so there is no wrap.
  - rounds saturates at 255 and does not wrap.
- Reset asserted mid-match or mid-blink: immediate clear of all state, independent of clock.

Decomposition:
- Package placar_pkg:
  - state typedef enum {PLAYING, OVER}.
  - Function therm(score, SEG) returning the thermometer pattern.
  - Helper function for popcount==1 and one-hot index.
- Sub-module edge_pulse (parameter WIDTH, ports clock, reset, in, q, pulse): the per-bit rising-edge detector, bypassed when EDGE_DETECT=0.

Test Plan:
1. Defaults; drive scores to 3/2, then pull reset low between clock edges -> all outputs 0 before the next rising edge. After release, win[0] pulse -> scores[3:0]=1.
2. EDGE_DETECT=1; hold win=2'b01 for 5 cycles -> score0=1 (not 5), rounds=1, led=16'h0001 one cycle after the score update.
3. win=2'b11 for 1 cycle -> scores unchanged, rounds incremented by 1, led unchanged.
4. BLINK_DIV=4; 8 separate win[1] pulses:
   - After the 8th: match_over=1, winner=1, led[15:8]=8'hFF.
   - led[15:8] toggles 8'h00/8'hFF every 4 cycles; led[7:0] shows player 0 steady.
   - A further win[0] pulse is ignored.
5. In OVER, new_match asserted in the same cycle as a win[0] rising edge -> next cycle scores=0, rounds=0, match_over=0, led=0. The win[0] edge is not counted.
6. N_PLAYERS=4, SCORE_W=3, WIN_TARGET=5, LED_W=16:
   - Player 2 scores 3 -> led[11:8]=4'b0111.
   - Two more player-2 wins -> match_over=1, winner=2, led[11:8] blinks 4'hF/4'h0.
   - Other players' scores unchanged.

Source files
------------

// File: rtl/placar_multi_pkg.sv
// Shared types and helpers for the multi-player match scoreboard.
package placar_pkg;

  typedef enum logic {
    PLAYING = 1'b0,
    OVER    = 1'b1
  } state_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] therm(input int score, input int seg);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < score) && (i < seg);
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

  function automatic int onehot_idx(input logic [MAX_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/placar_multi_if.sv
// Game-core / LED-board side signals of the scoreboard.
interface placar_multi_if #(
  parameter int N_PLAYERS = 2,
  parameter int SCORE_W   = 4,
  parameter int LED_W     = 16,
  parameter int WINNER_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
);
  logic [N_PLAYERS-1:0]         win;
  logic                         new_match;
  logic [N_PLAYERS*SCORE_W-1:0] scores;
  logic [LED_W-1:0]             led;
  logic                         match_over;
  logic [WINNER_W-1:0]          winner;
  logic [7:0]                   rounds;

  modport master (
    output win, new_match,
    input  scores, led, match_over, winner, rounds
  );

  modport slave (
    input  win, new_match,
    output scores, led, match_over, winner, rounds
  );
endinterface

// File: rtl/placar_multi_edge_pulse.sv
// Per-bit rising-edge detector; passes the input through when ENABLE is clear.
module edge_pulse #(
  parameter int WIDTH  = 1,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pulse
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= in;
  end

  assign pulse = ENABLE ? (in & ~q) : in;

endmodule

// File: rtl/placar_multi.sv
// Saturating N-player match scoreboard with winner detection and blinking LED thermometer.
//   state   | meaning
//   PLAYING | round wins are scored; first player to WIN_TARGET ends the match
//   OVER    | scores frozen, winner segment blinks until new_match
module placar_multi
  import placar_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_TARGET  = 8,
  parameter int LED_W       = 16,
  parameter int BLINK_DIV   = 50_000_000,
  parameter int EDGE_DETECT = 1
) (
  input logic            clock,
  input logic            reset,
  placar_multi_if.slave  bus
);

  localparam int SEG      = LED_W / N_PLAYERS;
  localparam int WINNER_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                             state_q, state_d;
  logic [N_PLAYERS-1:0][SCORE_W-1:0]  scores_q, scores_d;
  logic [7:0]                         rounds_q, rounds_d;
  logic                               over_q, over_d;
  logic [WINNER_W-1:0]                winner_q, winner_d;
  logic                               phase_q, phase_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [LED_W-1:0]                   led_q, led_d;

  logic [N_PLAYERS-1:0] ev;
  logic [N_PLAYERS-1:0] unused_win_q;
  logic [MAX_W-1:0]     ev_wide;
  int                   hit;

  edge_pulse #(
    .WIDTH  (N_PLAYERS),
    .ENABLE (EDGE_DETECT != 0)
  ) u_edge (
    .clock (clock),
    .reset (reset),
    .in    (bus.win),
    .q     (unused_win_q),
    .pulse (ev)
  );

  assign ev_wide = MAX_W'(ev);
  assign hit     = onehot_idx(ev_wide);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= PLAYING;
      scores_q <= '0;
      rounds_q <= '0;
      over_q   <= 1'b0;
      winner_q <= '0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      scores_q <= scores_d;
      rounds_q <= rounds_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    rounds_d = rounds_q;
    over_d   = over_q;
    winner_d = winner_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    led_d    = '0;

    // LED image lags the scores by one clock; the winner segment follows the blink phase
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (state_q == OVER && winner_q == WINNER_W'(p))
        led_d[p*SEG +: SEG] = {SEG{phase_q}};
      else
        led_d[p*SEG +: SEG] = SEG'(therm(int'(scores_q[p]), SEG));
    end

    if (bus.new_match) begin
      state_d  = PLAYING;
      scores_d = '0;
      rounds_d = '0;
      over_d   = 1'b0;
      winner_d = '0;
      phase_d  = 1'b0;
      cnt_d    = '0;
      led_d    = '0;
    end else begin
      case (state_q)
        PLAYING: begin
          if (ev != '0) begin
            if (rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
            // simultaneous wins are a drawn round: counted, but nobody scores
            if (is_onehot(ev_wide)) begin
              for (int p = 0; p < N_PLAYERS; p++) begin
                if (p == hit) begin
                  scores_d[p] = scores_q[p] + SCORE_W'(1);
                  if (scores_d[p] == SCORE_W'(WIN_TARGET)) begin
                    state_d  = OVER;
                    over_d   = 1'b1;
                    winner_d = WINNER_W'(p);
                    phase_d  = 1'b1;
                    cnt_d    = '0;
                  end
                end
              end
            end
          end
        end
        OVER: begin
          if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = PLAYING;
      endcase
    end
  end

  assign bus.scores     = scores_q;
  assign bus.rounds     = rounds_q;
  assign bus.match_over = over_q;
  assign bus.winner     = winner_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_placar_multi.sv
// Directed bench for placar_multi: a 2-player instance checked against a cycle model, a 4-player instance checked directly.
module tb_placar_multi;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  placar_multi_if #(.N_PLAYERS(2), .SCORE_W(4), .LED_W(16), .WINNER_W(1)) ifa ();
  placar_multi_if #(.N_PLAYERS(4), .SCORE_W(3), .LED_W(16), .WINNER_W(2)) ifb ();

  placar_multi #(
    .N_PLAYERS(2), .SCORE_W(4), .WIN_TARGET(8), .LED_W(16), .BLINK_DIV(4), .EDGE_DETECT(1)
  ) dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  placar_multi #(
    .N_PLAYERS(4), .SCORE_W(3), .WIN_TARGET(5), .LED_W(16), .BLINK_DIV(4), .EDGE_DETECT(1)
  ) dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  typedef struct packed {
    logic [7:0]  scores;
    logic [15:0] led;
    logic        over;
    logic        winner;
    logic [7:0]  rounds;
  } exp_t;

  exp_t exp_q[$];

  int         m_sc[2];
  int         m_rounds;
  int         m_cnt;
  logic       m_over;
  logic       m_win;
  logic       m_phase;
  logic [1:0] m_wq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sc[0] = 0; m_sc[1] = 0;
    m_rounds = 0; m_cnt = 0;
    m_over = 1'b0; m_win = 1'b0; m_phase = 1'b0;
    m_wq = 2'b00;
  endtask

  // one clock of the 2-player instance: drive, predict, push, wait, pop, compare
  task automatic tick_a(input logic [1:0] w, input logic nm);
    exp_t        e;
    logic [1:0]  ev;
    logic [15:0] led_n;
    logic [15:0] tmp;
    int          n;
    ifa.win = w;
    ifa.new_match = nm;
    ev = w & ~m_wq;
    m_wq = w;
    for (int i = 0; i < 2; i++) begin
      if (m_over && (m_win == i[0])) begin
        led_n[i*8 +: 8] = m_phase ? 8'hFF : 8'h00;
      end else begin
        n = (m_sc[i] > 8) ? 8 : m_sc[i];
        tmp = (16'h1 << n) - 16'h1;
        led_n[i*8 +: 8] = tmp[7:0];
      end
    end
    if (nm) begin
      model_reset();
      m_wq = w;
      led_n = 16'h0;
    end else if (!m_over) begin
      if (ev != 2'b00) begin
        m_rounds = (m_rounds == 255) ? 255 : m_rounds + 1;
        if (ev == 2'b01 || ev == 2'b10) begin
          n = (ev == 2'b10) ? 1 : 0;
          m_sc[n] = m_sc[n] + 1;
          if (m_sc[n] == 8) begin
            m_over = 1'b1; m_win = n[0]; m_phase = 1'b1; m_cnt = 0;
          end
        end
      end
    end else begin
      if (m_cnt == 3) begin
        m_cnt = 0; m_phase = ~m_phase;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.scores = {4'(m_sc[1]), 4'(m_sc[0])};
    e.led    = led_n;
    e.over   = m_over;
    e.winner = m_win;
    e.rounds = 8'(m_rounds);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("a_scores", 32'(ifa.scores), 32'(e.scores));
    chk("a_led",    32'(ifa.led),    32'(e.led));
    chk("a_over",   32'(ifa.match_over), 32'(e.over));
    chk("a_winner", 32'(ifa.winner), 32'(e.winner));
    chk("a_rounds", 32'(ifa.rounds), 32'(e.rounds));
  endtask

  task automatic tick_b(input logic [3:0] w);
    ifb.win = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.win = '0; ifa.new_match = 1'b0;
    ifb.win = '0; ifb.new_match = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_scores", 32'(ifa.scores), 32'h0);
    chk("rst_led",    32'(ifa.led), 32'h0);
    chk("rst_over",   32'(ifa.match_over), 32'h0);
    chk("rst_rounds", 32'(ifa.rounds), 32'h0);
    chk("rst_b_scores", 32'(ifb.scores), 32'h0);

    // test 1: build 3/2, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin tick_a(2'b01, 1'b0); tick_a(2'b00, 1'b0); end
    for (int i = 0; i < 2; i++) begin tick_a(2'b10, 1'b0); tick_a(2'b00, 1'b0); end
    chk("t1_scores_32", 32'(ifa.scores), 32'h23);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_scores", 32'(ifa.scores), 32'h0);
    chk("t1_async_led",    32'(ifa.led), 32'h0);
    chk("t1_async_over",   32'(ifa.match_over), 32'h0);
    chk("t1_async_rounds", 32'(ifa.rounds), 32'h0);
    chk("t1_async_winner", 32'(ifa.winner), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick_a(2'b01, 1'b0);
    chk("t1_after_rst", 32'(ifa.scores[3:0]), 32'h1);
    tick_a(2'b00, 1'b0);

    // test 2: held level counts once
    tick_a(2'b00, 1'b1);
    tick_a(2'b01, 1'b0);
    chk("t2_score_first", 32'(ifa.scores), 32'h01);
    chk("t2_led_lag", 32'(ifa.led), 32'h0000);
    tick_a(2'b01, 1'b0);
    chk("t2_led", 32'(ifa.led), 32'h0001);
    for (int i = 0; i < 3; i++) tick_a(2'b01, 1'b0);
    chk("t2_score_held", 32'(ifa.scores), 32'h01);
    chk("t2_rounds", 32'(ifa.rounds), 32'h1);
    tick_a(2'b00, 1'b0);

    // test 3: simultaneous wins are a drawn round
    tick_a(2'b11, 1'b0);
    chk("t3_scores", 32'(ifa.scores), 32'h01);
    chk("t3_rounds", 32'(ifa.rounds), 32'h2);
    tick_a(2'b00, 1'b0);
    chk("t3_led", 32'(ifa.led), 32'h0001);

    // test 4: player 1 reaches target, winner segment blinks every 4 cycles
    for (int i = 0; i < 8; i++) begin
      tick_a(2'b10, 1'b0);
      if (i < 7) tick_a(2'b00, 1'b0);
    end
    chk("t4_over",   32'(ifa.match_over), 32'h1);
    chk("t4_winner", 32'(ifa.winner), 32'h1);
    chk("t4_scores", 32'(ifa.scores), 32'h81);
    for (int i = 1; i <= 12; i++) begin
      tick_a(2'b00, 1'b0);
      chk("t4_blink", 32'(ifa.led[15:8]), (((i - 1) / 4) % 2 == 0) ? 32'hFF : 32'h00);
      chk("t4_p0_steady", 32'(ifa.led[7:0]), 32'h01);
    end
    tick_a(2'b01, 1'b0);
    tick_a(2'b00, 1'b0);
    chk("t4_ignored", 32'(ifa.scores), 32'h81);
    chk("t4_rounds", 32'(ifa.rounds), 32'd10);

    // test 5: new_match beats a coincident win edge
    tick_a(2'b01, 1'b1);
    chk("t5_scores", 32'(ifa.scores), 32'h0);
    chk("t5_rounds", 32'(ifa.rounds), 32'h0);
    chk("t5_over",   32'(ifa.match_over), 32'h0);
    chk("t5_led",    32'(ifa.led), 32'h0);
    tick_a(2'b01, 1'b0);
    chk("t5_no_recount", 32'(ifa.scores), 32'h0);
    tick_a(2'b00, 1'b0);

    // test 6: four players, player 2 wins at 5
    for (int i = 0; i < 3; i++) begin tick_b(4'b0100); tick_b(4'b0000); end
    chk("t6_scores3", 32'(ifb.scores), 32'h0C0);
    chk("t6_led3",    32'(ifb.led[11:8]), 32'h7);
    tick_b(4'b0100); tick_b(4'b0000);
    tick_b(4'b0100);
    chk("t6_over",   32'(ifb.match_over), 32'h1);
    chk("t6_winner", 32'(ifb.winner), 32'h2);
    chk("t6_scores5", 32'(ifb.scores), 32'h140);
    chk("t6_rounds", 32'(ifb.rounds), 32'h5);
    tick_b(4'b0000);
    chk("t6_blink_on",  32'(ifb.led[11:8]), 32'hF);
    chk("t6_others",    32'({ifb.led[15:12], ifb.led[7:0]}), 32'h0);
    for (int i = 0; i < 4; i++) tick_b(4'b0000);
    chk("t6_blink_off", 32'(ifb.led[11:8]), 32'h0);
    tick_b(4'b0001); tick_b(4'b0000);
    chk("t6_frozen", 32'(ifb.scores), 32'h140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
